// File: rtl/arb_req_agent_if.sv
`default_nettype none
// ============================================================================
// Module      : arb_req_agent_if
// Description : Arbiter request/grant lines plus the shared data-bus
//               handshake used by arb_req_agent.
//                 req_out   agent -> arbiter  per-client request lines
//                 gnt_in    arbiter -> agent  one-hot grant (combinational)
//                 bus_valid agent -> sink     a beat is presented
//                 bus_ready sink -> agent     sink accepts the beat
//                 bus_owner agent -> sink     client index owning the burst
//                 bus_beat  agent -> sink     beat index 0..BEATS-1
//                 bus_last  agent -> sink     final beat of the burst
//               Modports: master (agent side), slave (arbiter/sink side).
// Revision    : 1.0 - initial release
// ============================================================================
interface arb_req_agent_if #(
  parameter int N_CLI  = 4,
  parameter int BEAT_W = 2
);
  localparam int OWN_W = $clog2(N_CLI);

  logic [N_CLI-1:0]  req_out;
  logic [N_CLI-1:0]  gnt_in;
  logic              bus_valid;
  logic              bus_ready;
  logic [OWN_W-1:0]  bus_owner;
  logic [BEAT_W-1:0] bus_beat;
  logic              bus_last;

  modport master (
    output req_out,
    input  gnt_in,
    output bus_valid,
    input  bus_ready,
    output bus_owner,
    output bus_beat,
    output bus_last
  );

  modport slave (
    input  req_out,
    output gnt_in,
    input  bus_valid,
    output bus_ready,
    input  bus_owner,
    input  bus_beat,
    input  bus_last
  );
endinterface
`default_nettype wire

// File: rtl/arb_req_agent.sv
`default_nettype none
// ============================================================================
// Module      : arb_req_agent
// Description : Requester-side companion to a 4-way round-robin arbiter.
//               Counts pending requests per client, raises request lines
//               while idle, samples the arbiter's grant and runs a
//               fixed-length valid/ready burst for the granted client.
//               Requests are withheld during a burst and its trailing gap
//               so the arbiter rotates exactly once per transaction.
// Ports       : clk, rst       clock / asynchronous active-high reset
//               push           per-client one-cycle request pulses
//               bus            arb_req_agent_if.master (arbiter + data bus)
//               busy           FSM not idle
//               ovf            sticky per-client push-while-full flag
//               gnt_err        sticky grant-protocol error
// Options     : `define ARB_GNT_CHECK_EN enables grant-protocol checking;
//               otherwise gnt_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_req_agent #(
  parameter int N_CLI = 4,
  parameter int BEATS = 4,
  parameter int CNT_W = 3
) (
  input  wire               clk,
  input  wire               rst,
  input  wire [N_CLI-1:0]   push,
  arb_req_agent_if.master   bus,
  output logic              busy,
  output logic [N_CLI-1:0]  ovf,
  output logic              gnt_err
);

  localparam int OWN_W  = $clog2(N_CLI);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]  c_cnt_max   = '1;
  localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [OWN_W-1:0]  r_owner, w_owner_nxt;
  logic [BEAT_W-1:0] r_beat,  w_beat_nxt;

  logic [N_CLI-1:0]  w_pend;     // client has at least one pending request
  logic [N_CLI-1:0]  w_req;      // request lines as driven to the arbiter
  logic [N_CLI-1:0]  w_g;        // grants that match an active request
  logic [N_CLI-1:0]  w_dec;      // client whose grant is accepted this cycle
  logic              w_sel_vld;
  logic [OWN_W-1:0]  w_sel_idx;
  logic              w_last;

  // Requests are only exposed in IDLE, so any grant seen in BURST/GAP is
  // masked away here and therefore ignored.
  assign w_req = (r_state == S_IDLE) ? w_pend : '0;
  assign w_g   = bus.gnt_in & w_req;

  // Lowest set bit of the qualified grant wins; scanning downward lets the
  // last assignment be the lowest index.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int i = N_CLI - 1; i >= 0; i--) begin
      if (w_g[i]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = OWN_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-client pending counters and overflow flags
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CLI; gi++) begin : g_cli
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_full;
    logic             w_inc;

    assign w_dec[gi] = w_sel_vld && (w_sel_idx == OWN_W'(gi));
    assign w_full    = (r_cnt == c_cnt_max);
    // A push into a full counter still counts when a grant frees a slot in
    // the same cycle; the net effect is no change and no overflow.
    assign w_inc     = push[gi] && (!w_full || w_dec[gi]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_inc && !w_dec[gi]) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec[gi] && !w_inc) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        if (push[gi] && w_full && !w_dec[gi]) begin
          r_ovf <= 1'b1;
        end
      end
    end

    assign w_pend[gi] = |r_cnt;
    assign ovf[gi]    = r_ovf;
  end

  // --------------------------------------------------------------------------
  // Transaction FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  assign w_last = (r_state == S_BURST) && (r_beat == c_last_beat);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (w_sel_vld) begin
          w_owner_nxt = w_sel_idx;
          w_beat_nxt  = '0;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        // bus_valid is held high throughout BURST, so ready alone means a
        // beat transfers. The index stays at the last beat after the final
        // transfer so it can be observed during GAP/IDLE.
        if (bus.bus_ready) begin
          if (w_last) begin
            w_state_nxt = S_GAP;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.req_out   = w_req;
  assign bus.bus_valid = (r_state == S_BURST);
  assign bus.bus_last  = w_last;
  assign bus.bus_owner = r_owner;
  assign bus.bus_beat  = r_beat;
  assign busy          = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Grant-protocol checker
  // --------------------------------------------------------------------------
`ifdef ARB_GNT_CHECK_EN
  logic r_gnt_err;
  logic w_multi;
  logic w_stray;

  // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
  assign w_multi = |(bus.gnt_in & (bus.gnt_in - N_CLI'(1)));
  assign w_stray = |(bus.gnt_in & ~w_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_err <= 1'b0;
    end else if ((r_state == S_IDLE) && (w_multi || w_stray)) begin
      r_gnt_err <= 1'b1;
    end
  end

  assign gnt_err = r_gnt_err;
`else
  assign gnt_err = 1'b0;
`endif

endmodule
`default_nettype wire
